// File: rtl/memory.sv
// ============================================================================
//  Module   : memory
//  Purpose  : Byte-addressed little-endian RAM with wrapping word accesses,
//             registered read data and a registered write-complete pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module memory #(
    parameter int DEPTH      = 128,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         CLK,
    input  logic                         clr,
    input  logic                         CS,
    input  logic                         WE,
    input  logic [31:0]                  WADDR,
    input  logic [$clog2(DEPTH)-1:0]     RADDR,
    input  logic [DATA_WIDTH-1:0]        Mem_in,
    output logic [DATA_WIDTH-1:0]        Mem_out,
    output logic                         writefinish
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [7:0]            mem [DEPTH];
    logic [ADDR_W-1:0]     widx [NBYTES];
    logic [ADDR_W-1:0]     ridx [NBYTES];
    logic [DATA_WIDTH-1:0] rd_word;

    // Byte lane addresses wrap naturally through ADDR_W-bit addition.
    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        assign widx[g] = WADDR[ADDR_W-1:0] + ADDR_W'(g);
        assign ridx[g] = RADDR + ADDR_W'(g);
        assign rd_word[8*g +: 8] = mem[ridx[g]];
    end

    // Read samples the pre-write array because both updates are non-blocking.
    always_ff @(posedge CLK) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'(i);
            end
            Mem_out     <= '0;
            writefinish <= 1'b0;
        end else begin
            writefinish <= CS & WE;
            if (CS) begin
                Mem_out <= rd_word;
                if (WE) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        mem[widx[k]] <= Mem_in[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory.sv
// ============================================================================
//  Module   : tb_memory
//  Purpose  : Directed and random checks of memory against a byte-array model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory;

    localparam int DEPTH = 128;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int AW    = 7;

    logic          CLK = 1'b0;
    logic          clr = 1'b1;
    logic          CS  = 1'b0;
    logic          WE  = 1'b0;
    logic [31:0]   WADDR = '0;
    logic [AW-1:0] RADDR = '0;
    logic [DW-1:0] Mem_in = '0;
    logic [DW-1:0] Mem_out;
    logic          writefinish;

    memory #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .clr(clr), .CS(CS), .WE(WE), .WADDR(WADDR), .RADDR(RADDR),
        .Mem_in(Mem_in), .Mem_out(Mem_out), .writefinish(writefinish)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0]    model [DEPTH];
    logic [DW-1:0] exp_out = '0;
    logic          exp_wf  = 1'b0;

    function automatic logic [DW-1:0] model_read(input int addr);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < NB; k++) w[8*k +: 8] = model[(addr + k) % DEPTH];
        return w;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies one clock of stimulus, advances the model and checks both outputs.
    task automatic cyc(input logic c, input logic cs, input logic we,
                       input logic [31:0] wa, input logic [AW-1:0] ra, input logic [DW-1:0] din);
        clr = c; CS = cs; WE = we; WADDR = wa; RADDR = ra; Mem_in = din;
        @(posedge CLK);
        if (c) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 8'(i);
            exp_out = '0;
            exp_wf  = 1'b0;
        end else begin
            exp_wf = cs & we;
            if (cs) begin
                exp_out = model_read(int'(ra));
                if (we) for (int k = 0; k < NB; k++) model[(int'(wa % DEPTH) + k) % DEPTH] = din[8*k +: 8];
            end
        end
        #1;
        check("mem_out", Mem_out, exp_out);
        check("writefinish", {31'b0, writefinish}, {31'b0, exp_wf});
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        check("reset_out", Mem_out, 32'h0);

        cyc(0, 1, 0, 0, 7'h00, 0);
        check("read_00", Mem_out, 32'h03020100);
        cyc(0, 1, 0, 0, 7'h7E, 0);
        check("read_7e_wrap", Mem_out, 32'h01007F7E);

        cyc(0, 1, 1, 32'h82, 7'h40, 32'h1);
        check("wf_single", {31'b0, writefinish}, 32'h1);
        cyc(0, 1, 0, 0, 7'h00, 0);
        check("wf_single_end", {31'b0, writefinish}, 32'h0);
        check("alias_read_00", Mem_out, 32'h00010100);
        cyc(0, 1, 0, 0, 7'h02, 0);
        check("alias_read_02", Mem_out, 32'h00000001);

        for (int n = 1; n <= 3; n++) begin
            cyc(0, 1, 1, 32'h10, 7'h50, DW'(n));
            check("wf_burst", {31'b0, writefinish}, 32'h1);
        end
        cyc(0, 1, 0, 0, 7'h10, 0);
        check("burst_read", Mem_out, 32'h00000003);

        cyc(0, 1, 1, 32'h20, 7'h20, 32'hAABBCCDD);
        check("rbw_old", Mem_out, 32'h23222120);
        cyc(0, 1, 0, 0, 7'h20, 0);
        check("rbw_new", Mem_out, 32'hAABBCCDD);

        cyc(0, 0, 1, 32'h30, 7'h00, 32'hDEADBEEF);
        check("cs0_hold", Mem_out, 32'hAABBCCDD);
        check("cs0_wf", {31'b0, writefinish}, 32'h0);
        cyc(0, 1, 0, 0, 7'h30, 0);
        check("cs0_nowrite", Mem_out, 32'h33323130);

        cyc(0, 1, 1, 32'h40, 7'h00, 32'h11111111);
        cyc(1, 1, 1, 32'h40, 7'h00, 32'h22222222);
        cyc(0, 1, 0, 0, 7'h40, 0);
        check("reset_abort", Mem_out, 32'h43424140);

        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
                $urandom, AW'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter DEPTH, default 128, SHALL set the storage size in bytes; it SHALL be a power of two.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the word width in bits; it SHALL be a multiple of 8.
REQ-003 Port CLK, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port clr, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-005 Port CS, input, 1 bit, SHALL be the chip select; when low, reads and writes SHALL be disabled.
REQ-006 Port WE, input, 1 bit, SHALL be the write enable.
REQ-007 Port WADDR, input, 32 bits, SHALL be the byte write address; only bits [log2(DEPTH)-1:0] SHALL be used.
REQ-008 Port RADDR, input, log2(DEPTH) bits (7 at default), SHALL be the byte read address.
REQ-009 Port Mem_in, input, DATA_WIDTH bits, SHALL be the write data.
REQ-010 Port Mem_out, output, DATA_WIDTH bits, SHALL be the registered read data.
REQ-011 Port writefinish, output, 1 bit, SHALL be the registered write-complete pulse.

Function
REQ-012 Storage SHALL be DEPTH bytes, mem[0..DEPTH-1], and SHALL be byte addressed.
REQ-013 Word layout SHALL be little-endian: byte k of a word at address A SHALL be bits [8k+7:8k] and SHALL map to mem[(A+k) mod DEPTH].
REQ-014 Multi-byte accesses SHALL wrap modulo DEPTH; there is no alignment requirement.
REQ-015 Write: when CS=1, WE=1 and clr=0 at a rising edge, all DATA_WIDTH/8 bytes of Mem_in SHALL be stored at WADDR per REQ-013.
REQ-016 writefinish SHALL be 1 in the cycle after each accepted write, and 0 otherwise.
REQ-017 WE held high for N cycles SHALL perform N writes and SHALL produce N consecutive writefinish cycles.
REQ-018 Read: when CS=1 and clr=0 at a rising edge, Mem_out SHALL load the word at RADDR per REQ-013.
REQ-019 Read latency SHALL be 1 cycle (RADDR presented in cycle t, data on Mem_out in cycle t+1).
REQ-020 When CS=0, Mem_out SHALL hold its previous value, no write SHALL occur, and writefinish SHALL be 0.
REQ-021 A read and write in the same cycle with overlapping bytes SHALL return the pre-write contents (read-before-write); the new data SHALL be visible from the next read.
REQ-022 WADDR bits above log2(DEPTH)-1 SHALL be ignored (address 0x82 SHALL alias to 0x02 at DEPTH=128).
REQ-023 There SHALL be no read enable; with CS=1 a read SHALL occur every cycle.

Reset
REQ-024 While clr=1 at a rising edge, every byte mem[i] SHALL be set to i mod 256.
REQ-025 While clr=1, Mem_out SHALL be set to 0 and writefinish SHALL be set to 0.
REQ-026 Writes during reset SHALL be discarded.
REQ-027 Reset asserted during a write burst SHALL abort the burst; no partial word from the reset cycle SHALL be stored.
REQ-028 The first read SHALL be valid one cycle after clr deasserts.

Verification
REQ-029 Reset, then RADDR=0x00 with CS=1 -> Mem_out=0x03020100 one cycle later.
REQ-030 Reset, then RADDR=0x7E -> Mem_out=0x01007F7E (wrap-around).
REQ-031 Reset, then one-cycle write with WADDR=0x82 and Mem_in=0x00000001 -> writefinish=1 for exactly the next cycle; a subsequent read of RADDR=0x00 -> 0x00010100; a read of RADDR=0x02 -> 0x00000001.
REQ-032 WE=1 for 3 cycles with WADDR=0x10 and Mem_in=1, 2, 3 -> writefinish high for 3 cycles; a read of RADDR=0x10 -> 0x00000003.
REQ-033 Simultaneous write of 0xAABBCCDD and read at RADDR=WADDR=0x20 -> Mem_out=0x23222120, then 0xAABBCCDD on the next read.
REQ-034 CS=0 with WE=1 -> memory unchanged, Mem_out holds its value, writefinish=0.
